// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, bus widths
// and reset-time constants.
package if_stage_pkg;

  localparam int unsigned IF_ADDR_W = 30;
  localparam int unsigned IF_DATA_W = 32;

  localparam logic [IF_DATA_W-1:0] ISA_NOP          = 32'h0000_0000;
  localparam logic [IF_ADDR_W-1:0] RESET_VECTOR_DEF = '0;

  typedef enum logic [1:0] {
    IF_REQ     = 2'd0,
    IF_WAIT    = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

  // A memory request is in flight in these states and its address must not move.
  function automatic logic req_pending(input if_state_e s);
    return (s == IF_WAIT) || (s == IF_DISCARD);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory fetch bus: word address/request out, one-cycle ready pulse
// with read data back.
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
);
  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemRdy;
  logic [DATA_W-1:0] IMemRdData;

  modport master (output IMemReq, output IMemAddr, input IMemRdy, input IMemRdData);
  modport slave  (input IMemReq, input IMemAddr, output IMemRdy, output IMemRdData);
endinterface

// File: rtl/if_stage_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer that parks a fetched
// word returning while the pipeline is stalled.
module if_stage_reg
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W       = IF_ADDR_W,
  parameter int                DATA_W       = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              upd_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] insn_i,
  input  logic              skid_wr_i,
  input  logic              skid_clr_i,
  input  logic [ADDR_W-1:0] skid_pc_i,
  input  logic [DATA_W-1:0] skid_insn_i,
  output logic [ADDR_W-1:0] ifpc_o,
  output logic [DATA_W-1:0] ifinsn_o,
  output logic              ifen_o,
  output logic              skid_vld_o,
  output logic [ADDR_W-1:0] skid_pc_o,
  output logic [DATA_W-1:0] skid_insn_o
);

  logic [ADDR_W-1:0] ifpc_q;
  logic [DATA_W-1:0] ifinsn_q;
  logic              ifen_q;
  logic              skid_vld_q;
  logic [ADDR_W-1:0] skid_pc_q;
  logic [DATA_W-1:0] skid_insn_q;

  // A bubble keeps IFPC and forces the NOP encoding into IFInsn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifpc_q     <= RESET_VECTOR;
      ifinsn_q   <= NOP_INSN;
      ifen_q     <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      if (upd_i) begin
        ifen_q   <= vld_i;
        ifinsn_q <= vld_i ? insn_i : NOP_INSN;
        if (vld_i) ifpc_q <= pc_i;
      end
      if (skid_clr_i)     skid_vld_q <= 1'b0;
      else if (skid_wr_i) skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (skid_wr_i) begin
      skid_pc_q   <= skid_pc_i;
      skid_insn_q <= skid_insn_i;
    end
  end

  assign ifpc_o      = ifpc_q;
  assign ifinsn_o    = ifinsn_q;
  assign ifen_o      = ifen_q;
  assign skid_vld_o  = skid_vld_q;
  assign skid_pc_o   = skid_pc_q;
  assign skid_insn_o = skid_insn_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: program counter, fetch request FSM and redirect
// handling in front of the decode stage.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W       = IF_ADDR_W,
  parameter int                DATA_W       = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = ISA_NOP
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] NewPC,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrAddr,
  if_stage_if.master        imem,
  output logic [ADDR_W-1:0] IFPC,
  output logic [DATA_W-1:0] IFInsn,
  output logic              IFEn,
  output logic              IFBusy
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req;
  logic              pending;
  logic              redirect;
  logic              upd, ld_vld;
  logic [ADDR_W-1:0] ld_pc;
  logic [DATA_W-1:0] ld_insn;
  logic              skid_wr, skid_clr, skid_vld;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_insn;

  // A taken branch under Stall is dropped; decode presents it again.
  assign redirect = Flush || (BrTaken && !Stall);
  assign pending  = req_pending(state_q) && !imem.IMemRdy;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IF_REQ;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req      = 1'b0;
    upd      = 1'b0;
    ld_vld   = 1'b0;
    ld_pc    = addr_q;
    ld_insn  = imem.IMemRdData;
    skid_wr  = 1'b0;
    skid_clr = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        upd = !Stall;
        // A redirect this cycle withholds the request so the new PC goes out next.
        if (!redirect) begin
          req     = 1'b1;
          addr_d  = pc_q;
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        req = 1'b1;
        if (imem.IMemRdy) begin
          if (Stall) begin
            skid_wr = 1'b1;
            state_d = IF_HOLD;
          end else begin
            upd     = 1'b1;
            ld_vld  = 1'b1;
            pc_d    = pc_q + PC_ONE;
            state_d = IF_REQ;
          end
        end else begin
          upd = !Stall;
        end
      end
      IF_HOLD: begin
        if (!Stall) begin
          upd      = 1'b1;
          ld_vld   = skid_vld;
          ld_pc    = skid_pc;
          ld_insn  = skid_insn;
          skid_clr = 1'b1;
          pc_d     = pc_q + PC_ONE;
          state_d  = IF_REQ;
        end
      end
      IF_DISCARD: begin
        req = 1'b1;
        upd = !Stall;
        if (imem.IMemRdy) state_d = IF_REQ;
      end
      default: state_d = IF_REQ;
    endcase
    if (redirect) begin
      pc_d     = Flush ? NewPC : BrAddr;
      upd      = 1'b1;
      ld_vld   = 1'b0;
      skid_wr  = 1'b0;
      skid_clr = 1'b1;
      state_d  = pending ? IF_DISCARD : IF_REQ;
    end
  end

  assign imem.IMemReq  = req && reset_;
  assign imem.IMemAddr = (state_q == IF_REQ) ? pc_q : addr_q;
  assign IFBusy        = pending;

  if_stage_reg #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RESET_VECTOR (RESET_VECTOR),
    .NOP_INSN     (NOP_INSN)
  ) u_reg (
    .clk_i       (clk),
    .rst_ni      (reset_),
    .upd_i       (upd),
    .vld_i       (ld_vld),
    .pc_i        (ld_pc),
    .insn_i      (ld_insn),
    .skid_wr_i   (skid_wr),
    .skid_clr_i  (skid_clr),
    .skid_pc_i   (addr_q),
    .skid_insn_i (imem.IMemRdData),
    .ifpc_o      (IFPC),
    .ifinsn_o    (IFInsn),
    .ifen_o      (IFEn),
    .skid_vld_o  (skid_vld),
    .skid_pc_o   (skid_pc),
    .skid_insn_o (skid_insn)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a behavioural instruction memory that
// returns 32'hA0 + word address after a programmable latency.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [29:0] NewPC = '0;
  logic        BrTaken = 1'b0;
  logic [29:0] BrAddr = '0;
  logic [29:0] IFPC;
  logic [31:0] IFInsn;
  logic        IFEn;
  logic        IFBusy;

  int n_chk = 0;
  int n_err = 0;
  int lat = 1;

  if_stage_if #(.ADDR_W(30), .DATA_W(32)) imem_bus ();

  if_stage #(
    .ADDR_W       (30),
    .DATA_W       (32),
    .RESET_VECTOR (30'h0),
    .NOP_INSN     (32'h0)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .Stall   (Stall),
    .Flush   (Flush),
    .NewPC   (NewPC),
    .BrTaken (BrTaken),
    .BrAddr  (BrAddr),
    .imem    (imem_bus),
    .IFPC    (IFPC),
    .IFInsn  (IFInsn),
    .IFEn    (IFEn),
    .IFBusy  (IFBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: a request seen mid-cycle is accepted at the next edge; Rdy pulses
  // lat cycles after acceptance.
  initial begin : mem_model
    logic        active;
    logic        mreq_s;
    logic [29:0] maddr_s, maddr;
    int          cnt;
    active = 1'b0;
    cnt    = 0;
    maddr  = '0;
    imem_bus.IMemRdy    = 1'b0;
    imem_bus.IMemRdData = '0;
    forever begin
      @(negedge clk);
      mreq_s  = imem_bus.IMemReq;
      maddr_s = imem_bus.IMemAddr;
      @(posedge clk);
      #1;
      if (!reset_) begin
        active = 1'b0;
        imem_bus.IMemRdy = 1'b0;
      end else if (imem_bus.IMemRdy) begin
        imem_bus.IMemRdy = 1'b0;
        active = 1'b0;
      end else if (active) begin
        if (!mreq_s) active = 1'b0;
        else begin
          cnt--;
          if (cnt == 0) begin
            imem_bus.IMemRdy    = 1'b1;
            imem_bus.IMemRdData = 32'hA0 + {2'b00, maddr};
          end
        end
      end else if (mreq_s) begin
        active = 1'b1;
        maddr  = maddr_s;
        cnt    = lat - 1;
        if (cnt == 0) begin
          imem_bus.IMemRdy    = 1'b1;
          imem_bus.IMemRdData = 32'hA0 + {2'b00, maddr};
        end
      end
    end
  end

  initial begin : stim
    #2;
    check("rst_req",   imem_bus.IMemReq, 0);
    check("rst_ifen",  IFEn, 0);
    check("rst_ifpc",  IFPC, 0);
    check("rst_insn",  IFInsn, 0);
    check("rst_busy",  IFBusy, 0);

    repeat (2) @(posedge clk);
    #2 reset_ = 1'b1;

    // Sequential fetch with a 1-cycle memory: one instruction every 2 cycles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("seq_addr", imem_bus.IMemAddr, i >> 1);
      check("seq_ifen", IFEn, (i >= 2 && i % 2 == 0) ? 1 : 0);
      if (i >= 2 && i % 2 == 0) begin
        check("seq_ifpc", IFPC, i / 2 - 1);
        check("seq_insn", IFInsn, 32'hA0 + i / 2 - 1);
      end
    end
    @(negedge clk);
    check("seq3_ifpc", IFPC, 3);
    check("seq3_insn", IFInsn, 32'hA3);
    check("seq4_addr", imem_bus.IMemAddr, 4);
    lat = 4;

    // Slow memory: three busy cycles, bubbles, stable address.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("slow_busy", IFBusy, 1);
      check("slow_ifen", IFEn, 0);
      check("slow_addr", imem_bus.IMemAddr, 4);
      check("slow_req",  imem_bus.IMemReq, 1);
    end
    @(negedge clk);
    check("slow_done_busy", IFBusy, 0);
    lat = 1;
    @(negedge clk);
    check("slow_ifen4", IFEn, 1);
    check("slow_ifpc4", IFPC, 4);
    check("slow_insn4", IFInsn, 32'hA4);
    check("slow_addr5", imem_bus.IMemAddr, 5);

    // Stall in the cycle word 5 returns: it parks in the skid buffer.
    @(posedge clk);
    #2 Stall = 1'b1;
    @(negedge clk);
    check("stall_ifen", IFEn, 0);
    check("stall_ifpc", IFPC, 4);
    check("stall_insn", IFInsn, 0);
    @(negedge clk);
    check("hold_req",  imem_bus.IMemReq, 0);
    check("hold_ifen", IFEn, 0);
    @(negedge clk);
    check("hold_req2",  imem_bus.IMemReq, 0);
    check("hold_ifpc2", IFPC, 4);
    @(posedge clk);
    #2 Stall = 1'b0;
    @(negedge clk);
    check("unstall_ifen0", IFEn, 0);
    @(negedge clk);
    check("skid_ifen", IFEn, 1);
    check("skid_ifpc", IFPC, 5);
    check("skid_insn", IFInsn, 32'hA5);
    check("skid_addr6", imem_bus.IMemAddr, 6);
    check("skid_req",  imem_bus.IMemReq, 1);
    @(negedge clk);
    @(negedge clk);
    check("f6_ifpc", IFPC, 6);
    check("f6_insn", IFInsn, 32'hA6);
    check("f7_addr", imem_bus.IMemAddr, 7);
    lat = 3;

    // Taken branch while fetch of 7 is outstanding.
    @(posedge clk);
    #2;
    BrTaken = 1'b1;
    BrAddr  = 30'h100;
    @(negedge clk);
    check("br_addr_hold", imem_bus.IMemAddr, 7);
    check("br_req_hold",  imem_bus.IMemReq, 1);
    @(posedge clk);
    #2 BrTaken = 1'b0;
    @(negedge clk);
    check("br_ifen", IFEn, 0);
    check("br_addr_hold2", imem_bus.IMemAddr, 7);
    lat = 1;
    @(negedge clk);
    check("br_drop_ifen", IFEn, 0);
    @(negedge clk);
    check("br_tgt_addr", imem_bus.IMemAddr, 30'h100);
    check("br_tgt_req",  imem_bus.IMemReq, 1);
    check("br_tgt_ifen", IFEn, 0);
    @(negedge clk);
    @(negedge clk);
    check("br_tgt_ifen1", IFEn, 1);
    check("br_tgt_ifpc",  IFPC, 30'h100);
    check("br_tgt_insn",  IFInsn, 32'h1A0);
    check("br_next_addr", imem_bus.IMemAddr, 30'h101);

    // Flush wins over Stall and BrTaken.
    @(posedge clk);
    #2;
    Flush   = 1'b1;
    NewPC   = 30'h40;
    Stall   = 1'b1;
    BrTaken = 1'b1;
    BrAddr  = 30'h200;
    @(posedge clk);
    #2;
    Flush   = 1'b0;
    Stall   = 1'b0;
    BrTaken = 1'b0;
    @(negedge clk);
    check("fl_ifen", IFEn, 0);
    check("fl_insn", IFInsn, 0);
    check("fl_addr", imem_bus.IMemAddr, 30'h40);
    check("fl_req",  imem_bus.IMemReq, 1);
    @(negedge clk);
    @(negedge clk);
    check("fl_ifen1", IFEn, 1);
    check("fl_ifpc",  IFPC, 30'h40);
    check("fl_insn1", IFInsn, 32'hE0);
    check("fl_next",  imem_bus.IMemAddr, 30'h41);

    // PC wrap at the top of the word address space.
    @(posedge clk);
    #2;
    Flush = 1'b1;
    NewPC = 30'h3FFF_FFFF;
    @(posedge clk);
    #2 Flush = 1'b0;
    @(negedge clk);
    check("wrap_addr", imem_bus.IMemAddr, 30'h3FFF_FFFF);
    check("wrap_ifen0", IFEn, 0);
    @(negedge clk);
    @(negedge clk);
    check("wrap_ifen", IFEn, 1);
    check("wrap_ifpc", IFPC, 30'h3FFF_FFFF);
    check("wrap_insn", IFInsn, 32'h4000_009F);
    check("wrap_next", imem_bus.IMemAddr, 0);
    lat = 4;

    // Asynchronous reset while a fetch is outstanding.
    @(negedge clk);
    check("prerst_busy", IFBusy, 1);
    #2 reset_ = 1'b0;
    #1;
    check("arst_req",  imem_bus.IMemReq, 0);
    check("arst_ifen", IFEn, 0);
    check("arst_ifpc", IFPC, 0);
    check("arst_insn", IFInsn, 0);
    check("arst_busy", IFBusy, 0);
    check("arst_addr", imem_bus.IMemAddr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
